// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/read-data back.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Instruction memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, handshakes with instruction memory and presents
// each fetched word as instruction/pc with instr_valid. Next PC is pc+4 or
// pc+imm_ext on a taken branch; a misaligned target halts until reset.
module instr_fetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]      instruction,
  output logic [XLEN-1:0]      pc,
  output logic                 instr_valid,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      imm_ext,
  output logic                 misaligned
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] target;

  // Candidate next PC; 32-bit wrap-around, carry dropped.
  always_comb begin
    target = pc_q + (branch_taken ? imm_ext : PC_STEP);
  end

  // Next-state and next-value logic for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          valid_d = 1'b0;
          if (target[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    req_d = (state_d == FETCH);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= XLEN'(RESET_PC);
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      req_q   <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign pc             = pc_q;
  assign instr_valid    = valid_q;
  assign misaligned     = mis_q;

endmodule
